seg_display_scan: RTL
=====================

// Module: seg_display_scan
// PURPOSE
//  Downstream display stage for the min/sec stopwatch counter. Takes the four BCD
//  digits (min1, min0, sec1, sec0) plus adjust/select mode and time-multiplexes them
//  onto a 4-digit common-anode 7-segment display. While adjusting, the selected digit
//  pair blinks so the user can see which field is being changed.
// PARAMETERS
//  REFRESH_DIV  100000      clk cycles each digit stays lit (1 kHz digit rate @100 MHz)
//  BLINK_DIV    25000000    clk cycles per blink half-period (2 Hz blink @100 MHz)
// PORTS
//  clk     in   1  system clock; all state on posedge
//  reset   in   1  synchronous, active-high reset
//  min1    in   4  BCD tens-of-minutes
//  min0    in   4  BCD minutes
//  sec1    in   4  BCD tens-of-seconds
//  sec0    in   4  BCD seconds
//  adjust  in   2  0 = run; 1/2 = adjust mode (fields blink); 3 = treated as adjust
//  select  in   1  1 = seconds field selected, 0 = minutes field selected
//  seg     out  7  segment cathodes {g,f,e,d,c,b,a}, active-low
//  dp      out  1  decimal point, active-low; held 1 (off)
//  an      out  4  digit anodes, active-low; an[0]=sec0 .. an[3]=min1
// BEHAVIOUR
//  - Reset (sync, wins over all else): refresh_cnt=0, digit_idx=0, blink_cnt=0,
//    blink_vis=1; outputs an=4'b1111, seg=7'h7F, dp=1.
//  - refresh_cnt: 0..REFRESH_DIV-1, +1 per cycle; at REFRESH_DIV-1 wraps to 0 and
//    digit_idx advances 0->1->2->3->0 (2-bit wrap). Each digit lit REFRESH_DIV cycles.
//  - Digit map: idx0=sec0, idx1=sec1, idx2=min0, idx3=min1.
//  - Outputs registered: an/seg on edge N reflect digit_idx, blink_vis and digit
//    inputs as held before edge N (1-cycle latency). Exactly one an bit low, except
//    during reset and the first cycle after it.
//  - Decode (hex, active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10;
//    any value 10..15 -> 3F (dash, only g lit). No latching of input digits.
//  - Blink: when adjust==0, blink_cnt=0 and blink_vis=1 every cycle (no blanking).
//    When adjust!=0, blink_cnt counts 0..BLINK_DIV-1, wraps and toggles blink_vis.
//    Entering adjust therefore always starts with a full visible half-period.
//  - Blank rule: adjust!=0 && blink_vis==0 && digit in selected pair (select=1:
//    idx0/1; select=0: idx2/3) -> seg=7'h7F; an still scans normally (constant
//    brightness timing). Unselected pair never blanked.
//  - select change mid-adjust: blink phase not reset; new pair blanks from next edge.
//  - Reset mid-scan: returns to idx0 next edge; blink state cleared.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: when idx3 is shown and min1==0, seg=7'h7F,
//    except while adjust!=0 && select==0 (minutes field being edited shows "0").
//  LEADING_ZERO_BLANK_EN undefined: min1==0 displays "0" (seg=40) always.
// TESTING (bench uses REFRESH_DIV=4, BLINK_DIV=8)
//  1 reset held 3 cycles -> an=1111, seg=7F, dp=1; release -> next edge an=1110.
//  2 digits 1,2,3,4 (min1..sec0), adjust=0 -> an 1110/1101/1011/0111 each 4 cycles,
//    seg 19/30/24/79 respectively, sequence repeats from 1110.
//  3 adjust=1, select=1 -> idx0/1 seg normal 8 cycles, 7F next 8, repeat;
//    idx2/3 never 7F; adjust->0 mid-blank -> segments visible next edge.
//  4 sec0=4'hC -> seg=3F while an=1110; min0=4'hF -> seg=3F while an=1011.
//  5 reset asserted while an=1011 -> next edge an=1111; after release scan restarts
//    at an=1110 with full 4-cycle dwell.
//  6 min1=0, adjust=0: with LEADING_ZERO_BLANK_EN seg=7F at an=0111, adjust=1,
//    select=0 -> seg=40 (visible phase); without macro seg=40 in all cases.

Source files
------------

// File: rtl/seg_display_scan.sv
`default_nettype none
// ============================================================================
//  Module      : seg_display_scan
//  Description : Scans four BCD digits onto a 4-digit common-anode 7-segment
//                display, blinking the selected field while adjusting.
//                Optional macro LEADING_ZERO_BLANK_EN blanks a leading zero
//                in the tens-of-minutes digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_display_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] min1,
    input  logic [3:0] min0,
    input  logic [3:0] sec1,
    input  logic [3:0] sec0,
    input  logic [1:0] adjust,
    input  logic       select,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int c_REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_REF_W-1:0]   c_REF_LAST   = c_REF_W'(REFRESH_DIV - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_DIV - 1);
    localparam logic [6:0]           c_SEG_OFF    = 7'h7F;

    logic [c_REF_W-1:0]   r_refresh_cnt;
    logic [1:0]           r_digit_idx;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 r_blink_vis;
    logic [6:0]           r_seg;
    logic [3:0]           r_an;

    logic [3:0] w_digit;
    logic [6:0] w_dec;
    logic [6:0] w_seg_next;
    logic       w_adjusting;
    logic       w_in_sel;

    assign w_adjusting = |adjust;
    // Seconds pair lives at idx0/1 (idx[1]=0), minutes pair at idx2/3.
    assign w_in_sel    = (r_digit_idx[1] != select);

    always_comb begin
        w_digit = sec0;
        case (r_digit_idx)
            2'd0: w_digit = sec0;
            2'd1: w_digit = sec1;
            2'd2: w_digit = min0;
            2'd3: w_digit = min1;
            default: w_digit = sec0;
        endcase
    end

    always_comb begin
        w_dec = 7'h3F;
        case (w_digit)
            4'd0: w_dec = 7'h40;
            4'd1: w_dec = 7'h79;
            4'd2: w_dec = 7'h24;
            4'd3: w_dec = 7'h30;
            4'd4: w_dec = 7'h19;
            4'd5: w_dec = 7'h12;
            4'd6: w_dec = 7'h02;
            4'd7: w_dec = 7'h78;
            4'd8: w_dec = 7'h00;
            4'd9: w_dec = 7'h10;
            default: w_dec = 7'h3F;
        endcase
    end

    always_comb begin
        w_seg_next = w_dec;
`ifdef LEADING_ZERO_BLANK_EN
        // Keep the zero visible while the minutes field is being edited.
        if (r_digit_idx == 2'd3 && min1 == 4'd0 && !(w_adjusting && !select))
            w_seg_next = c_SEG_OFF;
`endif
        if (w_adjusting && !r_blink_vis && w_in_sel)
            w_seg_next = c_SEG_OFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= 2'd0;
        end else if (r_refresh_cnt == c_REF_LAST) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= r_digit_idx + 2'd1;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + 1'b1;
        end
    end

    // Blink phase restarts visible on every entry into adjust mode.
    always_ff @(posedge clk) begin
        if (reset || !w_adjusting) begin
            r_blink_cnt <= '0;
            r_blink_vis <= 1'b1;
        end else if (r_blink_cnt == c_BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_blink_vis <= ~r_blink_vis;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_an  <= 4'b1111;
            r_seg <= c_SEG_OFF;
        end else begin
            r_an  <= ~(4'b0001 << r_digit_idx);
            r_seg <= w_seg_next;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = 1'b1;

endmodule
`default_nettype wire
